// File: rtl/oq_pkg.sv
// Shared types and helpers for the output-queue packer: FSM states, credit
// need calculation and strobe popcount.
package oq_pkg;

  typedef enum logic [2:0] {IDLE, HDR, DATA, FLUSH, DROP} state_e;

  // Word size in bytes for the default 192-bit memory word.
  localparam int OB = 24;

  // One header word plus the data words a packet of len bytes occupies.
  function automatic logic [31:0] need(input logic [15:0] len, input int ob);
    return 32'd1 + (32'(len) + 32'(ob) - 32'd1) / 32'(ob);
  endfunction

  function automatic logic [7:0] popcount(input logic [63:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + {7'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/axis_oq_packer_gearbox.sv
// Byte gearbox: appends strobed input bytes at the fill point and pops
// OUT_W-bit words off the bottom. Bytes above the fill point are always zero.
module byte_gearbox
  import oq_pkg::*;
#(
  parameter int IN_W   = 256,
  parameter int OUT_W  = 192,
  parameter int FILL_W = 7
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [IN_W-1:0]   data_i,
  input  logic [IN_W/8-1:0] strb_i,
  input  logic              pop_i,
  output logic [FILL_W-1:0] fill_o,
  output logic [OUT_W-1:0]  word_o
);
  localparam int IB  = IN_W/8;
  localparam int OBB = OUT_W/8;
  localparam int BW  = IN_W + OUT_W;

  logic [BW-1:0]     res_q, res_d, shifted;
  logic [FILL_W-1:0] fill_q, fill_d, base;
  logic [IN_W-1:0]   masked;

  always_comb begin
    masked = '0;
    for (int b = 0; b < IB; b++) masked[b*8 +: 8] = strb_i[b] ? data_i[b*8 +: 8] : 8'h00;
    shifted = pop_i ? (res_q >> OUT_W) : res_q;
    // A pop of a short final word empties the buffer.
    if (pop_i) base = (fill_q > FILL_W'(OBB)) ? fill_q - FILL_W'(OBB) : '0;
    else       base = fill_q;
    res_d  = shifted;
    fill_d = base;
    if (push_i) begin
      res_d  = shifted | (BW'(masked) << {base, 3'b000});
      fill_d = base + FILL_W'(popcount(64'(strb_i)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      res_q  <= '0;
      fill_q <= '0;
    end else begin
      res_q  <= res_d;
      fill_q <= fill_d;
    end
  end

  assign fill_o = fill_q;
  assign word_o = res_q[OUT_W-1:0];

endmodule

// File: rtl/axis_oq_packer.sv
// Output-queue input stage: per-queue credit admission, header word, then
// densely packed data words through the byte gearbox; refused packets dropped.
module axis_oq_packer
  import oq_pkg::*;
#(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128,
  parameter int OUT_WIDTH   = 192,
  parameter int NUM_QUEUES  = 5,
  parameter int QUEUE_WORDS = 104857,
  parameter int DST_POS     = 24,
  parameter int CNT_WIDTH   = 20
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [TDATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0]         s_axis_tstrb,
  input  logic [TUSER_WIDTH-1:0]           s_axis_tuser,
  input  logic                             s_axis_tlast,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [OUT_WIDTH-1:0]             m_data,
  output logic                             m_hdr,
  output logic                             m_last,
  output logic [$clog2(OUT_WIDTH/8):0]     m_bytes,
  output logic [NUM_QUEUES-1:0]            m_qmask,
  input  logic                             rel_valid,
  input  logic [$clog2(NUM_QUEUES)-1:0]    rel_queue,
  input  logic [CNT_WIDTH-1:0]             rel_words,
  output logic [NUM_QUEUES*CNT_WIDTH-1:0]  free_words,
  output logic [31:0]                      drop_count
);
  localparam int WB  = OUT_WIDTH/8;
  localparam int IB  = TDATA_WIDTH/8;
  localparam int FW  = $clog2(IB + 2*WB + 1);
  localparam int MBW = $clog2(WB) + 1;
  localparam logic [FW-1:0]      WB_F  = FW'(WB);
  localparam logic [FW-1:0]      WB2_F = FW'(2*WB);
  localparam logic [CNT_WIDTH:0] QMAX  = (CNT_WIDTH+1)'(QUEUE_WORDS);

  state_e                                  state_q, state_d;
  logic [TUSER_WIDTH-1:0]                  tuser_q;
  logic [NUM_QUEUES-1:0]                   mask_q, dmask;
  logic [NUM_QUEUES-1:0][CNT_WIDTH-1:0]    free_q, free_d;
  logic [NUM_QUEUES-1:0][CNT_WIDTH:0]      tsum;
  logic [31:0]                             drop_q, drop_d;
  logic [CNT_WIDTH-1:0]                    need_c;
  logic                                    admit, fits, gb_push, gb_pop;
  logic [FW-1:0]                           fill;
  logic [OUT_WIDTH-1:0]                    gb_word;

  byte_gearbox #(.IN_W(TDATA_WIDTH), .OUT_W(OUT_WIDTH), .FILL_W(FW)) u_gb (
    .clk_i(clk), .reset_i(reset), .push_i(gb_push), .data_i(s_axis_tdata),
    .strb_i(s_axis_tstrb), .pop_i(gb_pop), .fill_o(fill), .word_o(gb_word)
  );

  always_comb begin
    dmask  = s_axis_tuser[DST_POS +: NUM_QUEUES];
    need_c = CNT_WIDTH'(need(s_axis_tuser[15:0], WB));
    fits   = 1'b1;
    for (int q = 0; q < NUM_QUEUES; q++)
      if (dmask[q] && free_q[q] < need_c) fits = 1'b0;
    admit = (state_q == IDLE) && s_axis_tvalid && (dmask != '0) && fits;
  end

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    m_valid       = 1'b0;
    m_hdr         = 1'b0;
    m_last        = 1'b0;
    m_bytes       = '0;
    m_data        = gb_word;
    gb_push       = 1'b0;
    gb_pop        = 1'b0;
    drop_d        = drop_q;
    case (state_q)
      IDLE: if (s_axis_tvalid) state_d = admit ? HDR : DROP;
      HDR: begin
        m_valid = 1'b1;
        m_hdr   = 1'b1;
        m_data  = OUT_WIDTH'(tuser_q);
        m_bytes = MBW'(WB);
        if (m_ready) state_d = DATA;
      end
      DATA: begin
        m_valid       = (fill >= WB_F);
        m_bytes       = MBW'(WB);
        gb_pop        = m_valid && m_ready;
        // Accept while the residue can absorb a full beat after this cycle's pop.
        s_axis_tready = (fill < WB_F) || (gb_pop && fill < WB2_F);
        gb_push       = s_axis_tvalid && s_axis_tready;
        if (gb_push && s_axis_tlast) state_d = FLUSH;
      end
      FLUSH: begin
        m_valid = (fill != '0);
        m_last  = (fill <= WB_F);
        m_bytes = (fill >= WB_F) ? MBW'(WB) : MBW'(fill);
        gb_pop  = m_valid && m_ready;
        if (fill == '0 || (gb_pop && m_last)) state_d = IDLE;
      end
      DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = IDLE;
          drop_d  = (drop_q == '1) ? drop_q : drop_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Admission debit and read-side release fold into a single update per queue.
  always_comb begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      tsum[q] = {1'b0, free_q[q]};
      if (admit && dmask[q]) tsum[q] = tsum[q] - {1'b0, need_c};
      if (rel_valid && 32'(rel_queue) == q) tsum[q] = tsum[q] + {1'b0, rel_words};
      free_d[q] = (tsum[q] > QMAX) ? CNT_WIDTH'(QUEUE_WORDS) : tsum[q][CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tuser_q <= '0;
      mask_q  <= '0;
      drop_q  <= '0;
      for (int q = 0; q < NUM_QUEUES; q++) free_q[q] <= CNT_WIDTH'(QUEUE_WORDS);
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      free_q  <= free_d;
      if (state_q == IDLE && s_axis_tvalid) begin
        tuser_q <= s_axis_tuser;
        mask_q  <= dmask;
      end
    end
  end

  assign m_qmask    = mask_q;
  assign free_words = free_q;
  assign drop_count = drop_q;

endmodule
